// File: rtl/doodler_motion.sv
// rtl/doodler_motion.sv - per-frame doodler motion, platform landing, scroll and score engine
// Platform checks are combinational over all eight platforms; every output is registered.
module doodler_motion #(
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 480,
  parameter int SCROLL_LINE = 200,
  parameter int JUMP_VEL    = 12,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 12,
  parameter int STEP        = 3,
  parameter int DOODLE_H    = 8,
  parameter int DOODLE_HW   = 4,
  parameter int START_X     = 160,
  parameter int START_Y     = 400
) (
  input  logic            frame_clk,
  input  logic            Reset,
  input  logic [7:0]      keycode,
  input  logic [7:0][9:0] Platform_X_in,
  input  logic [7:0][9:0] Platform_Y_in,
  input  logic [9:0]      platform_size,
  output logic [9:0]      Doodle_X,
  output logic [9:0]      Doodle_Y,
  output logic [9:0]      distance,
  output logic [7:0]      land_hit,
  output logic [15:0]     score,
  output logic            game_over,
  output logic [1:0]      state_out
);

  typedef enum logic [1:0] {READY = 2'd0, JUMPING = 2'd1, FALLING = 2'd2, DEAD = 2'd3} state_t;

  localparam logic [10:0]        L_W        = 11'(SCREEN_W);
  localparam logic [9:0]         L_STEP     = 10'(STEP);
  localparam logic [9:0]         L_WRAP_L   = 10'(SCREEN_W - STEP);
  localparam logic signed [10:0] L_SCROLL   = 11'(SCROLL_LINE);
  localparam logic [9:0]         L_SCROLL_Y = 10'(SCROLL_LINE);
  localparam logic signed [10:0] L_YMAX     = 11'(SCREEN_H - 1);
  localparam logic signed [10:0] L_DH       = 11'(DOODLE_H);
  localparam logic [9:0]         L_DH10     = 10'(DOODLE_H);
  localparam logic [10:0]        L_HW       = 11'(DOODLE_HW);
  localparam logic signed [5:0]  L_JUMP     = 6'(-JUMP_VEL);
  localparam logic signed [5:0]  L_GRAV     = 6'(GRAVITY);
  localparam logic signed [5:0]  L_MAXF     = 6'(MAX_FALL);
  localparam logic [9:0]         L_X0       = 10'(START_X);
  localparam logic [9:0]         L_Y0       = 10'(START_Y);
  localparam logic [7:0]         K_LEFT     = 8'h04;
  localparam logic [7:0]         K_RIGHT    = 8'h07;
  localparam logic [7:0]         K_START    = 8'h2C;

  state_t             r_state;
  logic [9:0]         r_x, r_y, r_dist;
  logic signed [5:0]  r_vel;
  logic [7:0]         r_land;
  logic [15:0]        r_score;
  logic               r_go;

  logic signed [10:0] w_ny, w_ny_bot;
  logic [10:0]        w_right;
  logic [9:0]         w_nx, w_dx, w_land_y, w_sdist;
  logic               w_hit, w_scroll, w_dead;
  logic [2:0]         w_idx;
  logic [7:0]         w_land;
  logic signed [5:0]  w_vel_inc, w_vel_next;
  logic [16:0]        w_score_sum;
  logic [15:0]        w_score_next;

  assign w_ny     = $signed({1'b0, r_y}) + 11'(r_vel);
  assign w_ny_bot = w_ny + L_DH;
  assign w_right  = {1'b0, r_x} + {1'b0, L_STEP};

  always_comb begin
    w_nx = r_x;
    if (keycode == K_LEFT)
      w_nx = (r_x < L_STEP) ? r_x + L_WRAP_L : r_x - L_STEP;
    else if (keycode == K_RIGHT)
      w_nx = (w_right >= L_W) ? 10'(w_right - L_W) : w_right[9:0];
  end

  // Scan high to low so the lowest qualifying index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = 3'd0;
    w_dx  = '0;
    for (int i = 7; i >= 0; i--) begin
      w_dx = (w_nx >= Platform_X_in[i]) ? w_nx - Platform_X_in[i] : Platform_X_in[i] - w_nx;
      if (!r_vel[5]
          && (({1'b0, r_y} + {1'b0, L_DH10}) <= {1'b0, Platform_Y_in[i]})
          && (w_ny_bot >= $signed({1'b0, Platform_Y_in[i]}))
          && ({1'b0, w_dx} < ({1'b0, platform_size} + L_HW))) begin
        w_hit = 1'b1;
        w_idx = 3'(i);
      end
    end
  end

  assign w_land       = w_hit ? (8'b1 << w_idx) : 8'b0;
  assign w_land_y     = Platform_Y_in[w_idx] - L_DH10;
  assign w_vel_inc    = r_vel + L_GRAV;
  assign w_vel_next   = (w_vel_inc > L_MAXF) ? L_MAXF : w_vel_inc;
  assign w_scroll     = r_vel[5] && (w_ny < L_SCROLL);
  assign w_sdist      = w_scroll ? 10'(L_SCROLL - w_ny) : 10'd0;
  assign w_dead       = w_ny_bot > L_YMAX;
  assign w_score_sum  = {1'b0, r_score} + {7'd0, w_sdist};
  assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state <= READY;
      r_x     <= L_X0;
      r_y     <= L_Y0;
      r_vel   <= '0;
      r_dist  <= '0;
      r_land  <= '0;
      r_score <= '0;
      r_go    <= 1'b0;
    end else begin
      r_land <= '0;
      r_dist <= '0;
      case (r_state)
        READY: begin
          if (keycode == K_START) begin
            r_state <= JUMPING;
            r_vel   <= L_JUMP;
            r_score <= '0;
          end
        end
        JUMPING, FALLING: begin
          r_x <= w_nx;
          if (w_hit) begin
            r_y     <= w_land_y;
            r_vel   <= L_JUMP;
            r_land  <= w_land;
            r_state <= JUMPING;
          end else if (w_dead) begin
            r_state <= DEAD;
            r_go    <= 1'b1;
          end else begin
            r_y     <= w_scroll ? L_SCROLL_Y : w_ny[9:0];
            r_dist  <= w_sdist;
            r_score <= w_score_next;
            r_vel   <= w_vel_next;
            r_state <= w_vel_next[5] ? JUMPING : FALLING;
          end
        end
        DEAD: begin
          if (keycode == K_START) begin
            r_state <= READY;
            r_x     <= L_X0;
            r_y     <= L_Y0;
            r_vel   <= '0;
            r_go    <= 1'b0;
          end
        end
        default: r_state <= READY;
      endcase
    end
  end

  assign Doodle_X  = r_x;
  assign Doodle_Y  = r_y;
  assign distance  = r_dist;
  assign land_hit  = r_land;
  assign score     = r_score;
  assign game_over = r_go;
  assign state_out = r_state;

endmodule

// File: tb/tb_doodler_motion.sv
// tb/tb_doodler_motion.sv - directed bench for doodler_motion with hand-computed trajectories
module tb_doodler_motion;

  logic            frame_clk;
  logic            Reset;
  logic [7:0]      keycode;
  logic [7:0][9:0] px, py;
  logic [9:0]      psize;
  logic [9:0]      Doodle_X, Doodle_Y, distance;
  logic [7:0]      land_hit;
  logic [15:0]     score;
  logic            game_over;
  logic [1:0]      state_out;

  int checks = 0;
  int errors = 0;
  int n;

  doodler_motion dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .Platform_X_in (px),
    .Platform_Y_in (py),
    .platform_size (psize),
    .Doodle_X      (Doodle_X),
    .Doodle_Y      (Doodle_Y),
    .distance      (distance),
    .land_hit      (land_hit),
    .score         (score),
    .game_over     (game_over),
    .state_out     (state_out)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic frame();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, state_out, 0);
    check({tag, "_x"}, Doodle_X, 160);
    check({tag, "_y"}, Doodle_Y, 400);
    check({tag, "_dist"}, distance, 0);
    check({tag, "_land"}, land_hit, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_go"}, game_over, 0);
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; px = '0; py = '0; psize = 10'd16;
    frame(); frame();
    check_reset("rst");
    Reset = 1'b0;
    frame();
    check("ready_hold_state", state_out, 0);
    check("ready_hold_y", Doodle_Y, 400);

    // Launch from spawn: 400 -> 388 -> ... -> 322 after 12 frames.
    keycode = 8'h2C; frame(); keycode = 8'h00;
    check("start_state", state_out, 1);
    check("start_y", Doodle_Y, 400);
    frame();
    check("rise1_y", Doodle_Y, 388);
    for (int i = 0; i < 10; i++) begin
      frame();
      check("rise_dist", distance, 0);
    end
    check("rise11_y", Doodle_Y, 323);
    check("rise11_state", state_out, 1);
    frame();
    check("peak_y", Doodle_Y, 322);
    check("peak_state", state_out, 2);
    check("peak_dist", distance, 0);

    // Single platform at (160,380): falling 322,323,325,...,367 then lands on the 11th frame.
    px[3] = 10'd160; py[3] = 10'd380;
    n = 0;
    while (land_hit == 8'h00 && n < 20) begin frame(); n++; end
    check("land3_frames", n, 11);
    check("land3_hit", land_hit, 8'h08);
    check("land3_y", Doodle_Y, 372);
    check("land3_state", state_out, 1);
    frame();
    check("land3_pulse_off", land_hit, 8'h00);

    // Two qualifying platforms: lowest index wins.
    px[3] = '0; py[3] = '0;
    px[2] = 10'd160; py[2] = 10'd380; px[5] = 10'd160; py[5] = 10'd380;
    psize = 10'd200;
    n = 0;
    while (land_hit == 8'h00 && n < 40) begin frame(); n++; end
    check("land25_hit", land_hit, 8'h04);
    check("land25_y", Doodle_Y, 372);

    // Horizontal wrap while bouncing on the wide platforms.
    keycode = 8'h04; frame();
    check("left1_x", Doodle_X, 157);
    for (int i = 0; i < 52; i++) frame();
    check("left_to1_x", Doodle_X, 1);
    frame();
    check("wrap_left_x", Doodle_X, 318);
    keycode = 8'h07; frame();
    check("wrap_right_x", Doodle_X, 1);
    keycode = 8'h00; frame();
    check("nokey_hold_x", Doodle_X, 1);

    // No platforms: fall to death, then restart.
    px = '0; py = '0; psize = 10'd16;
    n = 0;
    while (state_out != 2'd3 && n < 80) begin frame(); n++; end
    check("dead1_state", state_out, 3);
    check("dead1_go", game_over, 1);
    check("dead1_dist", distance, 0);
    check("dead1_land", land_hit, 0);
    keycode = 8'h2C; frame(); keycode = 8'h00;
    check("respawn_state", state_out, 0);
    check("respawn_x", Doodle_X, 160);
    check("respawn_y", Doodle_Y, 400);
    check("respawn_go", game_over, 0);
    frame();
    check("respawn_hold", state_out, 0);

    // Stair of platforms: lands at 322, 244, then 202 and scrolls.
    px[0] = 10'd160; py[0] = 10'd330;
    px[1] = 10'd160; py[1] = 10'd252;
    px[2] = 10'd160; py[2] = 10'd210;
    keycode = 8'h2C; frame(); keycode = 8'h00;
    check("run2_state", state_out, 1);
    check("run2_score", score, 0);
    repeat (12) frame();
    check("stair_peak1_y", Doodle_Y, 322);
    frame();
    check("stair_land0_hit", land_hit, 8'h01);
    check("stair_land0_y", Doodle_Y, 322);
    repeat (12) frame();
    check("stair_peak2_y", Doodle_Y, 244);
    check("stair_peak2_state", state_out, 2);
    frame();
    check("stair_land1_hit", land_hit, 8'h02);
    check("stair_land1_y", Doodle_Y, 244);
    repeat (12) frame();
    check("clamp_y", Doodle_Y, 200);
    check("clamp_dist", distance, 1);
    check("clamp_score", score, 34);
    frame(); frame();
    check("fall201_y", Doodle_Y, 201);
    frame();
    check("stair_land2_hit", land_hit, 8'h04);
    check("stair_land2_y", Doodle_Y, 202);
    check("stair_land2_dist", distance, 0);
    frame();
    check("scroll1_y", Doodle_Y, 200);
    check("scroll1_dist", distance, 10);
    check("scroll1_score", score, 44);
    frame();
    check("scroll2_dist", distance, 11);
    check("scroll2_score", score, 55);

    // Remaining scroll 10..1 adds 55, then free fall from 200 dies at Y=470.
    px = '0; py = '0;
    n = 0;
    while (state_out != 2'd3 && n < 80) begin frame(); n++; end
    check("dead2_state", state_out, 3);
    check("dead2_y", Doodle_Y, 470);
    check("dead2_score", score, 110);
    check("dead2_dist", distance, 0);
    check("dead2_go", game_over, 1);
    frame();
    check("dead2_frozen_y", Doodle_Y, 470);
    check("dead2_frozen_state", state_out, 3);
    keycode = 8'h2C; frame(); keycode = 8'h00;
    check("ready2_state", state_out, 0);
    check("ready2_score_held", score, 110);
    check("ready2_go", game_over, 0);
    keycode = 8'h2C; frame(); keycode = 8'h00;
    check("run3_state", state_out, 1);
    check("run3_score", score, 0);
    repeat (3) frame();
    check("run3_y", Doodle_Y, 367);

    // Reset mid-jump wins even with start held.
    Reset = 1'b1; keycode = 8'h2C;
    frame();
    check_reset("midrst");
    Reset = 1'b0; keycode = 8'h00;
    frame();
    check("post_rst_state", state_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/doodler_motion.md
Name: doodler_motion

Overview:
- Per-frame motion and collision engine for the player sprite; the counterpart to the platform manager.
- Consumes the eight platform positions and the platform half-width.
- Produces the sprite position, the per-frame world scroll amount (`distance`), one-hot landing pulses, score and game-over.
- Runs once per frame on frame_clk. All platform checks are combinational over the eight inputs; all state is registered.

Parameters:
- SCREEN_W, 320, horizontal wrap modulus in pixels
- SCREEN_H, 480, screen height; doodler bottom beyond SCREEN_H-1 means death
- SCROLL_LINE, 200, minimum doodler top Y while rising; excess scrolls the world
- JUMP_VEL, 12, launch speed in lines/frame (applied as -JUMP_VEL)
- GRAVITY, 1, velocity increment per frame
- MAX_FALL, 12, fall velocity saturation
- STEP, 3, horizontal move per frame
- DOODLE_H, 8, sprite height (Y is the top edge)
- DOODLE_HW, 4, sprite half-width (X is the centre)
- START_X, 160, spawn X
- START_Y, 400, spawn Y

Ports:
- frame_clk, in, 1: frame clock, rising edge
- Reset, in, 1: synchronous, active-high
- keycode, in, 8: 0x04 = left, 0x07 = right, 0x2C = start/restart
- Platform_X_in, in, [7:0][9:0]: platform centre X
- Platform_Y_in, in, [7:0][9:0]: platform top Y
- platform_size, in, 10: platform half-width
- Doodle_X, out, 10: sprite centre X
- Doodle_Y, out, 10: sprite top Y
- distance, out, 10: lines the world scrolls downward this frame
- land_hit, out, 8: one-hot, platform landed on this frame
- score, out, 16: accumulated scroll, saturating
- game_over, out, 1: high in DEAD
- state_out, out, 2: 0 READY, 1 JUMPING, 2 FALLING, 3 DEAD

Behaviour:
- Reset is synchronous, active-high, sampled on frame_clk. It wins over everything, including mid-jump. Reset values:
  - state READY, Doodle_X=START_X, Doodle_Y=START_Y
  - vel=0, distance=0, land_hit=0, score=0, game_over=0
- Internal Y arithmetic: 11-bit signed. vel: 6-bit signed. ny = Doodle_Y + vel.
- READY:
  - keycode 0x2C → JUMPING, vel=-JUMP_VEL, score=0.
  - Otherwise hold. No horizontal motion.
- JUMPING / FALLING, each frame, evaluated in this order:
  1. Horizontal:
     - 0x04: X-STEP; if X<STEP, X+SCREEN_W-STEP.
     - 0x07: X+STEP; if result ≥SCREEN_W, subtract SCREEN_W.
     - Any other keycode: hold.
  2. Landing, only when vel ≥ 0. Platform i qualifies if all hold:
     - Doodle_Y+DOODLE_H ≤ PY[i]
     - ny+DOODLE_H ≥ PY[i]
     - |Doodle_X-PX[i]| < platform_size+DOODLE_HW
     - If several qualify, the lowest index wins.
     - On a hit: Doodle_Y=PY[i]-DOODLE_H, vel=-JUMP_VEL, land_hit=1<<i for this frame only, state JUMPING, distance=0.
  3. No landing:
     - Rising with ny<SCROLL_LINE: Doodle_Y=SCROLL_LINE, distance=SCROLL_LINE-ny.
     - Otherwise Doodle_Y=ny, distance=0.
     - vel=min(vel+GRAVITY, MAX_FALL).
     - State is JUMPING while the new vel<0, else FALLING.
  4. Death: no landing and ny+DOODLE_H > SCREEN_H-1.
     - → DEAD, game_over=1, distance=0, Doodle_Y held.
     - Landing takes priority over death in the same frame.
- score += distance each frame, saturating at 0xFFFF.
- land_hit and distance are registered, valid for exactly the frame after the evaluating edge, and 0 otherwise.
- DEAD:
  - outputs frozen, game_over=1
  - keycode 0x2C → READY with the spawn position, vel=0, game_over=0
  - score is held until the next start.

Test Plan:
- Reset, then keycode 0x2C for one frame → state_out=1, vel=-12.
  - Next frame Doodle_Y=388.
  - Peak Doodle_Y=322 after 12 frames, then state_out=2.
  - distance=0 throughout.
- Platform 3 at (160,380), others at X=0/Y=0, after launch → in the falling phase land_hit=8'h08 for exactly one frame, Doodle_Y=372, state_out=1.
- Platforms 2 and 5 both at (160,380) → land_hit=8'h04 only.
- Landing leaves Doodle_Y=202 with vel=-12:
  - next frame Doodle_Y=200, distance=10, score +10
  - following frame distance=11, score +21 total.
- Doodle_X=1 with keycode 0x04 → Doodle_X=318. Doodle_X=318 with 0x07 → Doodle_X=1.
- No reachable platforms after launch:
  - game_over=1, state_out=3, distance=0
  - 0x2C → state_out=0, X=160, Y=400
  - 0x2C again → state_out=1, score=0
  - Reset asserted mid-jump → all reset values on the next edge.
